// File: rtl/dtlb_refill_ctl_pkg.sv
// Shared types and constants for the dtlb miss/refill and invalidate sequencer.
// The write-port bundle mirrors the dtlb write interface one-for-one.
package dtlb_refill_ctl_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int VPN_W_DEF = 51;
    localparam int DW_DEF    = 64;

    localparam int NWAYS     = 8;
    localparam int NSETS     = 16;
    localparam int WAY_W     = 3;
    localparam int SET_W     = 4;
    localparam int SWEEP_LEN = NWAYS * NSETS;
    localparam int CNT_W     = $clog2(SWEEP_LEN);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREQ,
        S_WWAIT,
        S_FILL,
        S_DONE,
        S_INV1,
        S_INV2,
        S_SWEEP,
        S_IACK
    } state_e;

    typedef struct packed {
        logic [VPN_W_DEF-1:0] addr;
        logic [DW_DEF-1:0]    data0;
        logic [DW_DEF-1:0]    data1;
        logic [DW_DEF-1:0]    data2;
        logic                 wen;
        logic                 xstant;
        logic                 invl;
        logic                 force_en;
        logic [WAY_W-1:0]     force_way;
    } tlb_wr_t;

endpackage

// File: rtl/dtlb_rr_arb.sv
// Round-robin picker over NREQ miss requesters; grant is combinational,
// the search start pointer advances past the winner only when adv is pulsed.
module dtlb_rr_arb #(
    parameter int NREQ = 4,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic            gnt_vld,
    output logic [PW-1:0]   gnt_idx
);

    logic [PW-1:0] ptr_q, ptr_d;

    // Scan from the far end back toward ptr so the closest requester wins last.
    always_comb begin
        int j;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv && gnt_vld) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dtlb_refill_ctl.sv
// dtlb miss/refill sequencer (one walk in flight, duplicates merged) plus
// single-page invalidate via read-port steal and a 128-cycle forced-way flush.
module dtlb_refill_ctl
    import dtlb_refill_ctl_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int VPN_W = VPN_W_DEF,
    parameter int DW    = DW_DEF,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       miss_req,
    input  logic [NREQ*VPN_W-1:0] miss_vpn,
    output logic                  done_valid,
    output logic [NREQ-1:0]       done_mask,
    output logic                  done_fault,
    output logic                  done_retry,
    output logic                  walk_req_valid,
    output logic [VPN_W-1:0]      walk_req_vpn,
    input  logic                  walk_req_ready,
    input  logic                  walk_rsp_valid,
    input  logic [DW-1:0]         walk_rsp_data0,
    input  logic [DW-1:0]         walk_rsp_data1,
    input  logic [DW-1:0]         walk_rsp_data2,
    input  logic                  walk_rsp_fault,
    input  logic                  inv_req,
    input  logic                  inv_all,
    input  logic [VPN_W-1:0]      inv_vpn,
    output logic                  inv_ack,
    output logic                  tlb_rd_steal,
    output logic [VPN_W-1:0]      tlb_rd_addr,
    output logic [VPN_W-1:0]      tlb_write_addr,
    output logic [DW-1:0]         tlb_write_data0,
    output logic [DW-1:0]         tlb_write_data1,
    output logic [DW-1:0]         tlb_write_data2,
    output logic                  tlb_write_wen,
    output logic                  tlb_write_xstant,
    output logic                  tlb_write_invl,
    output logic                  tlb_force_way_en,
    output logic [2:0]            tlb_force_way,
    output logic                  busy
);

    state_e                  state_q, state_d;
    logic [VPN_W-1:0]        vpn_q, vpn_d;
    logic [2:0][DW-1:0]      rsp_dat_q, rsp_dat_d;
    logic                    fault_q, fault_d;
    logic                    stale_q, stale_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    gnt_vld;
    logic [PW-1:0]           gnt_idx;
    logic                    arb_adv;
    tlb_wr_t                 wr;

    dtlb_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst),
        .req     (miss_req),
        .adv     (arb_adv),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d        = state_q;
        vpn_d          = vpn_q;
        rsp_dat_d      = rsp_dat_q;
        fault_d        = fault_q;
        stale_d        = stale_q;
        cnt_d          = cnt_q;
        arb_adv        = 1'b0;
        wr             = '0;
        walk_req_valid = 1'b0;
        walk_req_vpn   = '0;
        tlb_rd_steal   = 1'b0;
        tlb_rd_addr    = '0;
        done_valid     = 1'b0;
        done_mask      = '0;
        done_fault     = 1'b0;
        done_retry     = 1'b0;
        inv_ack        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (inv_req) begin
                    state_d = inv_all ? S_SWEEP : S_INV1;
                end else if (gnt_vld) begin
                    arb_adv = 1'b1;
                    vpn_d   = miss_vpn[int'(gnt_idx)*VPN_W +: VPN_W];
                    stale_d = 1'b0;
                    state_d = S_WREQ;
                end
            end
            S_WREQ: begin
                walk_req_valid = 1'b1;
                walk_req_vpn   = vpn_q;
                if (inv_req) stale_d = 1'b1;
                if (walk_req_ready) state_d = S_WWAIT;
            end
            S_WWAIT: begin
                if (inv_req) stale_d = 1'b1;
                if (walk_rsp_valid) begin
                    rsp_dat_d = {walk_rsp_data2, walk_rsp_data1, walk_rsp_data0};
                    fault_d   = walk_rsp_fault;
                    // An invalidate seen on the response cycle also poisons the result.
                    state_d   = (walk_rsp_fault || stale_q || inv_req) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                wr.addr  = vpn_q;
                wr.data0 = rsp_dat_q[0];
                wr.data1 = rsp_dat_q[1];
                wr.data2 = rsp_dat_q[2];
                wr.wen   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done_valid = 1'b1;
                for (int i = 0; i < NREQ; i++) begin
                    done_mask[i] = miss_req[i] && (miss_vpn[i*VPN_W +: VPN_W] == vpn_q);
                end
                done_fault = fault_q;
                done_retry = stale_q;
                stale_d    = 1'b0;
                state_d    = S_IDLE;
            end
            S_INV1: begin
                tlb_rd_steal = 1'b1;
                tlb_rd_addr  = inv_vpn;
                state_d      = S_INV2;
            end
            S_INV2: begin
                tlb_rd_steal = 1'b1;
                tlb_rd_addr  = inv_vpn;
                wr.addr      = inv_vpn;
                wr.wen       = 1'b1;
                wr.xstant    = 1'b1;
                wr.invl      = 1'b1;
                state_d      = S_IACK;
            end
            S_SWEEP: begin
                // Low counter bits walk the sets, high bits select the forced way.
                wr.addr[SET_W-1:0] = cnt_q[SET_W-1:0];
                wr.force_way       = cnt_q[CNT_W-1 -: WAY_W];
                wr.force_en        = 1'b1;
                wr.wen             = 1'b1;
                wr.xstant          = 1'b1;
                wr.invl            = 1'b1;
                cnt_d              = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SWEEP_LEN - 1)) state_d = S_IACK;
            end
            S_IACK: begin
                inv_ack = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            vpn_q     <= '0;
            rsp_dat_q <= '0;
            fault_q   <= 1'b0;
            stale_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            vpn_q     <= vpn_d;
            rsp_dat_q <= rsp_dat_d;
            fault_q   <= fault_d;
            stale_q   <= stale_d;
            cnt_q     <= cnt_d;
        end
    end

    assign tlb_write_addr   = wr.addr;
    assign tlb_write_data0  = wr.data0;
    assign tlb_write_data1  = wr.data1;
    assign tlb_write_data2  = wr.data2;
    assign tlb_write_wen    = wr.wen;
    assign tlb_write_xstant = wr.xstant;
    assign tlb_write_invl   = wr.invl;
    assign tlb_force_way_en = wr.force_en;
    assign tlb_force_way    = wr.force_way;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_dtlb_refill_ctl.sv
// Scoreboard bench for dtlb_refill_ctl: directed stimulus queues expected output
// events; a negedge monitor pops and compares every observed event.
module tb_dtlb_refill_ctl;

    localparam int NREQ = 4;
    localparam int VW   = 51;
    localparam int DW   = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      miss_req;
    logic [NREQ*VW-1:0]   miss_vpn;
    logic                 done_valid, done_fault, done_retry;
    logic [NREQ-1:0]      done_mask;
    logic                 walk_req_valid, walk_req_ready;
    logic [VW-1:0]        walk_req_vpn;
    logic                 walk_rsp_valid, walk_rsp_fault;
    logic [DW-1:0]        walk_rsp_data0, walk_rsp_data1, walk_rsp_data2;
    logic                 inv_req, inv_all, inv_ack;
    logic [VW-1:0]        inv_vpn;
    logic                 tlb_rd_steal;
    logic [VW-1:0]        tlb_rd_addr, tlb_write_addr;
    logic [DW-1:0]        tlb_write_data0, tlb_write_data1, tlb_write_data2;
    logic                 tlb_write_wen, tlb_write_xstant, tlb_write_invl;
    logic                 tlb_force_way_en;
    logic [2:0]           tlb_force_way;
    logic                 busy;

    always #5 clk = ~clk;

    dtlb_refill_ctl #(.NREQ(NREQ), .VPN_W(VW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_vpn(miss_vpn),
        .done_valid(done_valid), .done_mask(done_mask),
        .done_fault(done_fault), .done_retry(done_retry),
        .walk_req_valid(walk_req_valid), .walk_req_vpn(walk_req_vpn),
        .walk_req_ready(walk_req_ready),
        .walk_rsp_valid(walk_rsp_valid),
        .walk_rsp_data0(walk_rsp_data0), .walk_rsp_data1(walk_rsp_data1),
        .walk_rsp_data2(walk_rsp_data2), .walk_rsp_fault(walk_rsp_fault),
        .inv_req(inv_req), .inv_all(inv_all), .inv_vpn(inv_vpn), .inv_ack(inv_ack),
        .tlb_rd_steal(tlb_rd_steal), .tlb_rd_addr(tlb_rd_addr),
        .tlb_write_addr(tlb_write_addr),
        .tlb_write_data0(tlb_write_data0), .tlb_write_data1(tlb_write_data1),
        .tlb_write_data2(tlb_write_data2),
        .tlb_write_wen(tlb_write_wen), .tlb_write_xstant(tlb_write_xstant),
        .tlb_write_invl(tlb_write_invl),
        .tlb_force_way_en(tlb_force_way_en), .tlb_force_way(tlb_force_way),
        .busy(busy)
    );

    typedef struct packed {
        logic          dv;
        logic [3:0]    dm;
        logic          df;
        logic          dr;
        logic          ia;
        logic          wv;
        logic [VW-1:0] wvpn;
        logic          st;
        logic [VW-1:0] ra;
        logic          we;
        logic [VW-1:0] wa;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          xs;
        logic          iv;
        logic          fe;
        logic [2:0]    fw;
    } sig_t;

    typedef struct {
        sig_t s;
        int   cyc;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic sig_t cur_sig();
        sig_t s;
        s.dv = done_valid;  s.dm = done_mask;  s.df = done_fault;  s.dr = done_retry;
        s.ia = inv_ack;
        s.wv = walk_req_valid & walk_req_ready;
        s.wvpn = walk_req_vpn;
        s.st = tlb_rd_steal; s.ra = tlb_rd_addr;
        s.we = tlb_write_wen; s.wa = tlb_write_addr;
        s.d0 = tlb_write_data0; s.d1 = tlb_write_data1; s.d2 = tlb_write_data2;
        s.xs = tlb_write_xstant; s.iv = tlb_write_invl;
        s.fe = tlb_force_way_en; s.fw = tlb_force_way;
        return s;
    endfunction

    function automatic logic any_out();
        return |{done_valid, done_mask, done_fault, done_retry, walk_req_valid, walk_req_vpn,
                 inv_ack, tlb_rd_steal, tlb_rd_addr, tlb_write_addr, tlb_write_data0,
                 tlb_write_data1, tlb_write_data2, tlb_write_wen, tlb_write_xstant,
                 tlb_write_invl, tlb_force_way_en, tlb_force_way, busy};
    endfunction

    // Monitor: every cycle carrying an observable event consumes one expectation.
    always @(negedge clk) begin
        sig_t a;
        exp_t e;
        a = cur_sig();
        if (a.dv || a.ia || a.we || a.st || a.wv) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, a);
            end else begin
                e = sbq.pop_front();
                if (a !== e.s || (e.cyc >= 0 && e.cyc != cyc)) begin
                    miscompares++;
                    $display("FAIL event cyc got %0d required %0d sig got=%h required=%h",
                             cyc, e.cyc, a, e.s);
                end
            end
        end
    end

    function automatic sig_t e_walk(input logic [VW-1:0] v);
        sig_t s = '0;
        s.wv = 1'b1; s.wvpn = v;
        return s;
    endfunction

    function automatic sig_t e_fill(input logic [VW-1:0] v, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b, input logic [DW-1:0] c);
        sig_t s = '0;
        s.we = 1'b1; s.wa = v; s.d0 = a; s.d1 = b; s.d2 = c;
        return s;
    endfunction

    function automatic sig_t e_done(input logic [3:0] m, input logic f, input logic r);
        sig_t s = '0;
        s.dv = 1'b1; s.dm = m; s.df = f; s.dr = r;
        return s;
    endfunction

    function automatic sig_t e_steal(input logic [VW-1:0] v);
        sig_t s = '0;
        s.st = 1'b1; s.ra = v;
        return s;
    endfunction

    function automatic sig_t e_invw(input logic [VW-1:0] v);
        sig_t s = '0;
        s.st = 1'b1; s.ra = v; s.we = 1'b1; s.wa = v; s.xs = 1'b1; s.iv = 1'b1;
        return s;
    endfunction

    function automatic sig_t e_sweep(input logic [6:0] c);
        sig_t s = '0;
        s.we = 1'b1; s.xs = 1'b1; s.iv = 1'b1; s.fe = 1'b1;
        s.fw = c[6:4];
        s.wa[3:0] = c[3:0];
        return s;
    endfunction

    function automatic sig_t e_iack();
        sig_t s = '0;
        s.ia = 1'b1;
        return s;
    endfunction

    task automatic push(input sig_t s, input int c);
        exp_t e;
        e.s = s; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_vpn(input int p, input logic [VW-1:0] v);
        miss_vpn[p*VW +: VW] = v;
    endtask

    // which: 0 = walk handshake pending, 1 = done pulse, 2 = inv_ack pulse
    task automatic wait_sig(input int which, input int budget, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if ((which == 0 && walk_req_valid && walk_req_ready) ||
                (which == 1 && done_valid) || (which == 2 && inv_ack)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s got no event in %0d cycles, required one", name, budget);
        end
    endtask

    task automatic walk_rsp(input int dly, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic f);
        wait_sig(0, 50, "walk_req");
        tick();
        repeat (dly - 1) tick();
        walk_rsp_valid = 1'b1;
        walk_rsp_data0 = a; walk_rsp_data1 = b; walk_rsp_data2 = c;
        walk_rsp_fault = f;
        tick();
        walk_rsp_valid = 1'b0;
        walk_rsp_fault = 1'b0;
    endtask

    task automatic wait_done_drop(input logic [3:0] m);
        wait_sig(1, 50, "done");
        tick();
        miss_req = miss_req & ~m;
    endtask

    task automatic flush_expect(input int ncyc, input int d);
        for (int c = 0; c < ncyc; c++) push(e_sweep(7'(c)), d + 1 + c);
    endtask

    logic [VW-1:0] rr_vpn [4];
    int            d;

    initial begin
        #2_000_000;
        $display("FAIL watchdog no summary reached, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        miss_req = '0; miss_vpn = '0;
        walk_req_ready = 1'b1; walk_rsp_valid = 1'b0; walk_rsp_fault = 1'b0;
        walk_rsp_data0 = '0; walk_rsp_data1 = '0; walk_rsp_data2 = '0;
        inv_req = 1'b0; inv_all = 1'b0; inv_vpn = '0;
        repeat (3) tick();
        vectors++;
        if (any_out() !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got nonzero outputs, required all zero");
        end
        rst = 1'b1;
        tick();

        // Round robin: four distinct VPNs, served 0,1,2,3 twice.
        rr_vpn[0] = 51'h100; rr_vpn[1] = 51'h211; rr_vpn[2] = 51'h322; rr_vpn[3] = 51'h433;
        for (int p = 0; p < 4; p++) set_vpn(p, rr_vpn[p]);
        for (int rep = 0; rep < 2; rep++) begin
            miss_req = 4'hF;
            for (int k = 0; k < 4; k++) begin
                push(e_walk(rr_vpn[k]), -1);
                push(e_fill(rr_vpn[k], 64'hD000 + 64'(k), 64'hE000 + 64'(k), 64'hF000 + 64'(k)), -1);
                push(e_done(4'(1 << k), 1'b0, 1'b0), -1);
                walk_rsp(1, 64'hD000 + 64'(k), 64'hE000 + 64'(k), 64'hF000 + 64'(k), 1'b0);
                wait_done_drop(4'(1 << k));
            end
        end

        // Single miss on port 2, response three cycles after the handshake.
        set_vpn(2, 51'h1234);
        miss_req = 4'b0100;
        push(e_walk(51'h1234), -1);
        push(e_fill(51'h1234, 64'h1111, 64'h2222, 64'h3333), -1);
        push(e_done(4'b0100, 1'b0, 1'b0), -1);
        walk_rsp(3, 64'h1111, 64'h2222, 64'h3333, 1'b0);
        wait_done_drop(4'b0100);

        // Merge: ports 0 and 3 share a VPN; one walk, one pulse.
        set_vpn(0, 51'hABC); set_vpn(3, 51'hABC);
        miss_req = 4'b1001;
        push(e_walk(51'hABC), -1);
        push(e_fill(51'hABC, 64'hAA, 64'hBB, 64'hCC), -1);
        push(e_done(4'b1001, 1'b0, 1'b0), -1);
        walk_rsp(2, 64'hAA, 64'hBB, 64'hCC, 1'b0);
        wait_done_drop(4'b1001);

        // Fault, with the walker stalling the request for a few cycles.
        set_vpn(0, 51'h999);
        walk_req_ready = 1'b0;
        miss_req = 4'b0001;
        push(e_walk(51'h999), -1);
        push(e_done(4'b0001, 1'b1, 1'b0), -1);
        repeat (3) tick();
        walk_req_ready = 1'b1;
        walk_rsp(2, 64'h5, 64'h6, 64'h7, 1'b1);
        wait_done_drop(4'b0001);

        // Invalidate race during WWAIT: refill discarded, then invalidate runs.
        set_vpn(1, 51'h77);
        miss_req = 4'b0010;
        push(e_walk(51'h77), -1);
        push(e_done(4'b0010, 1'b0, 1'b1), -1);
        push(e_steal(51'h55), -1);
        push(e_invw(51'h55), -1);
        push(e_iack(), -1);
        wait_sig(0, 50, "race_walk");
        tick();
        inv_req = 1'b1; inv_all = 1'b0; inv_vpn = 51'h55;
        tick();
        walk_rsp_valid = 1'b1;
        walk_rsp_data0 = 64'h77; walk_rsp_data1 = 64'h78; walk_rsp_data2 = 64'h79;
        tick();
        walk_rsp_valid = 1'b0;
        wait_done_drop(4'b0010);
        wait_sig(2, 50, "race_iack");
        inv_req = 1'b0;
        tick();

        // Full flush: 128 consecutive forced writes, ack 129 cycles after IDLE.
        d = cyc;
        flush_expect(128, d);
        push(e_iack(), d + 129);
        inv_req = 1'b1; inv_all = 1'b1;
        wait_sig(2, 200, "flush_iack");
        inv_req = 1'b0; inv_all = 1'b0;
        tick();

        // Reset during the sweep at c=40.
        d = cyc;
        flush_expect(40, d);
        inv_req = 1'b1; inv_all = 1'b1;
        for (int n = 0; n < 100 && cyc != d + 41; n++) tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (any_out() !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_sweep got nonzero outputs, required all zero");
        end
        inv_req = 1'b0; inv_all = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_busy got %b required 0", busy);
        end

        // Late walk response in IDLE must be ignored.
        walk_rsp_valid = 1'b1;
        tick();
        walk_rsp_valid = 1'b0;
        repeat (2) tick();

        // Pointer is back at 0: port 1 beats port 3.
        set_vpn(1, 51'h3000); set_vpn(3, 51'h4000);
        push(e_walk(51'h3000), -1);
        push(e_fill(51'h3000, 64'h31, 64'h32, 64'h33), -1);
        push(e_done(4'b0010, 1'b0, 1'b0), -1);
        push(e_walk(51'h4000), -1);
        push(e_fill(51'h4000, 64'h41, 64'h42, 64'h43), -1);
        push(e_done(4'b1000, 1'b0, 1'b0), -1);
        miss_req = 4'b1010;
        walk_rsp(1, 64'h31, 64'h32, 64'h33, 1'b0);
        wait_done_drop(4'b0010);
        walk_rsp(1, 64'h41, 64'h42, 64'h43, 1'b0);
        wait_done_drop(4'b1000);

        // Sweep counter restarted at 0 after the reset.
        d = cyc;
        flush_expect(128, d);
        push(e_iack(), d + 129);
        inv_req = 1'b1; inv_all = 1'b1;
        wait_sig(2, 200, "flush2_iack");
        inv_req = 1'b0; inv_all = 1'b0;

        repeat (5) tick();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected got %0d pending, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
